ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter that sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Executes the full host-request sequence: clock inhibit, request-to-send, bit shifting on device clock, ACK check.
- Drives the bus open-drain through output-enable signals; the top-level ties the tri-states on PS2_CLK/PS2_DAT and feeds the pads back in.
- `busy` lets the keyboard receive path ignore bus activity while a command is in flight.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Sends one byte to the keyboard using the full host-request sequence:
// hold the clock low, pull the data line low as a start bit, release the
// clock, shift bits out on device falling edges, then check the ACK.
// The bus is driven open-drain through the two *_oe outputs.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,    // clock held low before data is pulled (120 us)
  parameter int REQ_CYCLES     = 100,     // both lines low before clock release (2 us)
  parameter int TIMEOUT_CYCLES = 1000000  // clock release to idle-after-ACK limit (20 ms)
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] REQ_LAST = PH_W'(REQ_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  // Falling edge 11 is the ACK slot; the counter then holds 10.
  localparam logic [3:0] ACK_SLOT = 4'd10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_IDLE
  } state_t;

  state_t state, next_state;

  logic [1:0]      clk_sync, dat_sync;
  logic            clk_prev;
  logic            clk_s, dat_s, clk_fall;
  logic [PH_W-1:0] ph_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity;

  logic            accept;
  logic            done_evt;
  logic            err_evt;
  logic [1:0]      err_kind;
  logic            send_bit_oe;
  logic            timed_out;

  assign clk_s     = clk_sync[1];
  assign dat_s     = dat_sync[1];
  assign clk_fall  = clk_prev & ~clk_s;
  assign timed_out = (to_cnt == TO_LIMIT);
  assign tx_ready  = (state == S_IDLE);
  assign busy      = ~tx_ready;

  // Two-flop synchronizers on the pad inputs plus one history flop for edge detection.
  // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // Idle bus level, so leaving reset never looks like a falling edge.
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and the one-cycle events that accompany transitions.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done_evt   = 1'b0;
    err_evt    = 1'b0;
    err_kind   = ERR_NONE;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          accept     = 1'b1;
          next_state = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (ph_cnt == INH_LAST) next_state = S_REQ;
      end
      S_REQ: begin
        if (ph_cnt == REQ_LAST) next_state = S_SEND;
      end
      S_SEND: begin
        if (timed_out) begin
          err_evt    = 1'b1;
          err_kind   = ERR_TIMEOUT;
          next_state = S_IDLE;
        end else if (clk_fall && bit_cnt == ACK_SLOT) begin
          if (dat_s) begin
            err_evt    = 1'b1;
            err_kind   = ERR_NOACK;
            next_state = S_IDLE;
          end else begin
            next_state = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (timed_out) begin
          err_evt    = 1'b1;
          err_kind   = ERR_TIMEOUT;
          next_state = S_IDLE;
        end else if (clk_s && dat_s) begin
          done_evt   = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Data-line level to drive after the current falling edge: 8 data bits LSB first,
  // then parity, then a released line as the stop bit.
  always_comb begin
    send_bit_oe = 1'b0;
    if (bit_cnt < 4'd8)       send_bit_oe = ~shift_reg[bit_cnt[2:0]];
    else if (bit_cnt == 4'd8) send_bit_oe = ~parity;
  end

  // Phase, timeout and bit counters plus the latched command byte.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ph_cnt    <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
    end else begin
      if ((state == S_INHIBIT || state == S_REQ) && next_state == state)
        ph_cnt <= ph_cnt + 1'b1;
      else
        ph_cnt <= '0;

      // Runs only once the clock is released; saturates instead of wrapping.
      if (state == S_SEND || state == S_WAIT_IDLE) begin
        if (!timed_out) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end

      if (accept) begin
        shift_reg <= tx_data;
        parity    <= ~^tx_data;
        bit_cnt   <= '0;
      end else if (state == S_SEND && clk_fall) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Registered bus drivers and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      tx_done  <= done_evt;
      tx_error <= err_evt;

      if (accept)       err_code <= ERR_NONE;
      else if (err_evt) err_code <= err_kind;

      ps2_clk_oe <= (state == S_INHIBIT) || (state == S_REQ);

      case (state)
        S_REQ:   ps2_dat_oe <= 1'b1;  // start bit
        S_SEND:  if (clk_fall) ps2_dat_oe <= send_bit_oe;
        default: ps2_dat_oe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
// Short timing parameters keep each transfer to a few hundred cycles.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int REQ  = 10;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic [1:0] err_code;
  logic       ps2_clk_oe, ps2_dat_oe;

  // Device side of the open-drain bus.
  logic dev_clk_rel = 1'b1;
  logic dev_dat_low = 1'b0;
  logic clk_line, dat_line;
  assign clk_line = ~ps2_clk_oe & dev_clk_rel;
  assign dat_line = ~ps2_dat_oe & ~dev_dat_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .err_code  (err_code),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference frame as the device should see it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Event monitor, sampled 1 ns after each rising edge.
  int cyc = 0, acc_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int acc_cyc = 0, clk_rise_cyc = 0, clk_fall_cyc = 0, dat_rise_cyc = 0, err_cyc = 0;
  logic [1:0] oe_after_err = 2'b00;
  logic p_clk_oe = 1'b0, p_dat_oe = 1'b0, p_busy = 1'b0, p_err = 1'b0;

  always begin
    @(posedge CLOCK_50);
    cyc++;
    #1;
    if (busy && !p_busy) begin acc_cnt++; acc_cyc = cyc; end
    if (ps2_clk_oe && !p_clk_oe) clk_rise_cyc = cyc;
    if (!ps2_clk_oe && p_clk_oe) clk_fall_cyc = cyc;
    if (ps2_dat_oe && !p_dat_oe && ps2_clk_oe) dat_rise_cyc = cyc;
    if (tx_done) done_cnt++;
    if (tx_error) begin err_cnt++; err_cyc = cyc; end
    if (tx_done && tx_error) both_cnt++;
    if (p_err) oe_after_err = {ps2_clk_oe, ps2_dat_oe};
    p_clk_oe = ps2_clk_oe;
    p_dat_oe = ps2_dat_oe;
    p_busy   = busy;
    p_err    = tx_error;
  end

  // Device: wait for the request-to-send, then clock out max_falls falling edges,
  // sampling the line before each rising edge and optionally ACKing.
  task automatic device_xfer(input bit ack, input int max_falls,
                             output logic [10:0] bits, output bit ok);
    int w;
    ok   = 1'b0;
    bits = '0;
    w    = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < INH + REQ + 50) begin
      @(negedge CLOCK_50);
      w++;
    end
    if (w >= INH + REQ + 50) return;
    ok      = 1'b1;
    bits[0] = dat_line;
    repeat (5) @(negedge CLOCK_50);
    for (int n = 1; n <= max_falls; n++) begin
      dev_clk_rel = 1'b0;
      repeat (HALF - 1) @(negedge CLOCK_50);
      if (n <= 10) bits[n] = dat_line;
      @(negedge CLOCK_50);
      dev_clk_rel = 1'b1;
      if (n == 10 && ack) dev_dat_low = 1'b1;
      if (n == 11) dev_dat_low = 1'b0;
      repeat (HALF) @(negedge CLOCK_50);
    end
  endtask

  task automatic wait_accept(input string tag, input int a0);
    int w;
    w = 0;
    while (acc_cnt == a0 && w < 20) begin @(negedge CLOCK_50); w++; end
    check({tag, "_accepted"}, acc_cnt - a0, 1);
  endtask

  task automatic wait_end(input string tag, input int ev0, input int limit);
    int w;
    w = 0;
    while (done_cnt + err_cnt == ev0 && w < limit) begin @(negedge CLOCK_50); w++; end
    check({tag, "_finished"}, done_cnt + err_cnt - ev0, 1);
  endtask

  // Full transfer with timing, frame and status checks.
  task automatic do_xfer(input logic [7:0] d, input bit ack, input string tag);
    logic [10:0] bits;
    bit ok;
    int a0, d0, e0, t;
    a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    @(negedge CLOCK_50);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_accept(tag, a0);
    tx_valid = 1'b0;
    t = acc_cyc;
    check({tag, "_ready_low"}, tx_ready, 0);
    device_xfer(ack, 11, bits, ok);
    check({tag, "_req_seen"}, ok, 1);
    wait_end(tag, d0 + e0, 200);
    @(negedge CLOCK_50);
    check({tag, "_frame"}, bits, model_frame(d));
    check({tag, "_clk_oe_start"}, clk_rise_cyc - t, 1);
    check({tag, "_clk_oe_len"}, clk_fall_cyc - clk_rise_cyc, INH + REQ);
    check({tag, "_dat_oe_start"}, dat_rise_cyc - t, INH + 1);
    check({tag, "_done_cnt"}, done_cnt - d0, ack ? 1 : 0);
    check({tag, "_err_cnt"}, err_cnt - e0, ack ? 0 : 1);
    check({tag, "_err_code"}, err_code, ack ? 2'b00 : 2'b10);
    check({tag, "_ready_after"}, tx_ready, 1);
    if (!ack) check({tag, "_oe_after_err"}, oe_after_err, 2'b00);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
  } vec_t;

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[6];
    logic [7:0]  b2b[3];
    logic [10:0] bits;
    bit          ok;
    int          a0, d0, e0, w;

    tbl[0] = '{8'hED, 1'b1};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h00, 1'b1};
    tbl[3] = '{8'hFF, 1'b1};
    tbl[4] = '{8'hF4, 1'b1};
    tbl[5] = '{8'hAB, 1'b0};

    // Reset state.
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    check("rst_err_code", err_code, 2'b00);

    // Table-driven transfers, including a missing ACK.
    for (int i = 0; i < 6; i++)
      do_xfer(tbl[i].data, tbl[i].ack, $sformatf("tbl%0d", i));

    // Randomized transfers against the frame model.
    for (int i = 0; i < 8; i++)
      do_xfer(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), $sformatf("rnd%0d", i));

    // Back-to-back with tx_valid held high.
    b2b[0] = 8'h3C; b2b[1] = 8'hC3; b2b[2] = 8'h81;
    a0 = acc_cnt; d0 = done_cnt;
    @(negedge CLOCK_50);
    tx_data  = b2b[0];
    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_accept($sformatf("b2b%0d", k), a0 + k);
      if (k < 2) tx_data = b2b[k+1];
      else       tx_valid = 1'b0;
      check($sformatf("b2b%0d_ready_low", k), tx_ready, 0);
      device_xfer(1'b1, 11, bits, ok);
      check($sformatf("b2b%0d_frame", k), bits, model_frame(b2b[k]));
      wait_end($sformatf("b2b%0d", k), d0 + k + err_cnt, 200);
    end
    check("b2b_done_cnt", done_cnt - d0, 3);

    // Device never clocks: timeout measured from the clock release.
    a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    @(negedge CLOCK_50);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    wait_accept("tmo", a0);
    tx_valid = 1'b0;
    device_xfer(1'b1, 0, bits, ok);
    check("tmo_req_seen", ok, 1);
    wait_end("tmo", d0 + e0, TO + 200);
    @(negedge CLOCK_50);
    check("tmo_latency", err_cyc - clk_fall_cyc, TO);
    check("tmo_err_code", err_code, 2'b01);
    check("tmo_no_done", done_cnt - d0, 0);

    // Reset during SEND after the fourth bit.
    a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    @(negedge CLOCK_50);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    wait_accept("rst_mid", a0);
    tx_valid = 1'b0;
    device_xfer(1'b1, 4, bits, ok);
    check("rst_mid_req_seen", ok, 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_mid_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_pulses", {tx_done, tx_error}, 2'b00);
    repeat (5) @(negedge CLOCK_50);
    check("rst_mid_no_events", (done_cnt - d0) + (err_cnt - e0), 0);
    do_xfer(8'hF4, 1'b1, "after_rst");

    // tx_valid pulsed mid-transfer is ignored.
    a0 = acc_cnt; d0 = done_cnt;
    @(negedge CLOCK_50);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    wait_accept("ign", a0);
    tx_valid = 1'b0;
    fork
      device_xfer(1'b1, 11, bits, ok);
      begin
        repeat (200) @(negedge CLOCK_50);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
      end
    join
    wait_end("ign", d0 + err_cnt, 200);
    check("ign_frame", bits, model_frame(8'hA5));
    w = 0;
    while (w < INH + 20) begin @(negedge CLOCK_50); w++; end
    check("ign_accepts", acc_cnt - a0, 1);
    check("ign_done_cnt", done_cnt - d0, 1);

    check("no_done_and_error_together", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
